// File: rtl/sabre_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : sabre_pkg                                               |
// | Purpose  : Shared types and constants for the blade sequencer:     |
// |            state encoding, length width, cm-per-metre factor and   |
// |            the target-length helper.                               |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
package sabre_pkg;

  localparam int LEN_W    = 9;
  localparam int CM_PER_M = 100;

  typedef enum logic [1:0] {
    OFF        = 2'd0,
    IGNITING   = 2'd1,
    ON         = 2'd2,
    RETRACTING = 2'd3
  } state_e;

  // Full configured length in cm; 3 m 63 cm = 363 still fits in LEN_W bits.
  function automatic logic [LEN_W-1:0] calc_target(input logic [1:0] m,
                                                   input logic [5:0] cm);
    return LEN_W'(m) * LEN_W'(CM_PER_M) + LEN_W'(cm);
  endfunction

endpackage
`default_nettype wire

// File: rtl/step_prescaler.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : step_prescaler                                          |
// | Purpose  : Modulo-DIV counter with synchronous clear. tick_o is    |
// |            high on the enabled cycle where the count is DIV-1;     |
// |            the count then wraps to 0.                              |
// | Ports    : clk, rst (async active-low), clr_i, en_i -> tick_o      |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module step_prescaler #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  // A clearing cycle never ticks, so a fresh state always waits DIV cycles.
  assign tick_o = en_i && !clr_i && (cnt_q == LAST);

endmodule
`default_nettype wire

// File: rtl/blade_ignition_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : blade_ignition_sequencer                                |
// | Purpose  : Ramps the displayed blade length up on ignition and     |
// |            down on shutdown / power exhaustion, and gates/dims the |
// |            emitted colour by extension and power-warning state.    |
// | Ports    : in  clk, rst(async low), on_in, len_m, len_cm,          |
// |                r_in/g_in/b_in, power_lvl, power_warn               |
// |            out blade_cm, r_out/g_out/b_out, state, ign_done,       |
// |                ret_done, busy                                      |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module blade_ignition_sequencer
  import sabre_pkg::*;
#(
  parameter int STEP_CM     = 5,
  parameter int STEP_DIV    = 4,
  parameter int FLICKER_DIV = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             on_in,
  input  logic [1:0]       len_m,
  input  logic [5:0]       len_cm,
  input  logic [7:0]       r_in,
  input  logic [7:0]       g_in,
  input  logic [7:0]       b_in,
  input  logic [7:0]       power_lvl,
  input  logic             power_warn,
  output logic [LEN_W-1:0] blade_cm,
  output logic [7:0]       r_out,
  output logic [7:0]       g_out,
  output logic [7:0]       b_out,
  output logic [1:0]       state,
  output logic             ign_done,
  output logic             ret_done,
  output logic             busy
);

  localparam int            SW     = LEN_W + 1;
  localparam logic [SW-1:0] STEP_W = SW'(STEP_CM);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] blade_q, blade_d;
  logic             ign_q, ign_d, ret_q, ret_d;
  logic [7:0]       r_q, g_q, b_q;
  logic             phase_q;

  logic [LEN_W-1:0] target;
  logic             go, step_tick, flick_tick;
  logic [SW-1:0]    ext_sum, ret_diff;
  logic [LEN_W-1:0] ext_val, ret_val;

  assign target = calc_target(len_m, len_cm);
  // Running out of power is treated exactly like switching off.
  assign go     = on_in && (power_lvl != 8'd0);
  assign busy   = (state_q == IGNITING) || (state_q == RETRACTING);

  // 10-bit step arithmetic: carry beyond target saturates, borrow clamps to 0.
  assign ext_sum  = {1'b0, blade_q} + STEP_W;
  assign ext_val  = (ext_sum > {1'b0, target}) ? target : ext_sum[LEN_W-1:0];
  assign ret_diff = {1'b0, blade_q} - STEP_W;
  assign ret_val  = ret_diff[LEN_W] ? '0 : ret_diff[LEN_W-1:0];

  step_prescaler #(.DIV(STEP_DIV)) u_step_ps (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (state_d != state_q),
    .en_i   (busy),
    .tick_o (step_tick)
  );

  step_prescaler #(.DIV(FLICKER_DIV)) u_flick_ps (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (!power_warn),
    .en_i   (power_warn),
    .tick_o (flick_tick)
  );

  // Loss of go always wins over length changes and completion checks.
  always_comb begin
    state_d = state_q;
    blade_d = blade_q;
    ign_d   = 1'b0;
    ret_d   = 1'b0;
    case (state_q)
      OFF: begin
        blade_d = '0;
        if (go) state_d = IGNITING;
      end
      IGNITING: begin
        if (!go) begin
          state_d = RETRACTING;
        end else if (blade_q == target) begin
          state_d = ON;
          ign_d   = 1'b1;
        end else if (step_tick) begin
          blade_d = ext_val;
        end
      end
      ON: begin
        if (!go)                    state_d = RETRACTING;
        else if (target > blade_q)  state_d = IGNITING;
        else if (target < blade_q)  blade_d = target;
      end
      RETRACTING: begin
        if (go) begin
          state_d = IGNITING;
        end else if (blade_q == '0) begin
          state_d = OFF;
          ret_d   = 1'b1;
        end else if (step_tick) begin
          blade_d = ret_val;
        end
      end
      default: state_d = OFF;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= OFF;
      blade_q <= '0;
      ign_q   <= 1'b0;
      ret_q   <= 1'b0;
      phase_q <= 1'b0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      blade_q <= blade_d;
      ign_q   <= ign_d;
      ret_q   <= ret_d;
      if (!power_warn)     phase_q <= 1'b0;
      else if (flick_tick) phase_q <= ~phase_q;
      // Colour follows the blade length as currently displayed.
      if (blade_q == '0) begin
        r_q <= '0;
        g_q <= '0;
        b_q <= '0;
      end else if (power_warn && phase_q) begin
        r_q <= r_in >> 1;
        g_q <= g_in >> 1;
        b_q <= b_in >> 1;
      end else begin
        r_q <= r_in;
        g_q <= g_in;
        b_q <= b_in;
      end
    end
  end

  assign blade_cm = blade_q;
  assign state    = state_q;
  assign ign_done = ign_q;
  assign ret_done = ret_q;
  assign r_out    = r_q;
  assign g_out    = g_q;
  assign b_out    = b_q;

endmodule
`default_nettype wire

// File: tb/tb_blade_ignition_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_blade_ignition_sequencer                             |
// | Purpose  : Directed scoreboard bench. Stimulus queues expected     |
// |            output snapshots tagged with a cycle number; a monitor  |
// |            compares them on the falling edge and flags any         |
// |            done pulse that was not expected.                       |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module tb_blade_ignition_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       on_in = 1'b0;
  logic [1:0] len_m = '0;
  logic [5:0] len_cm = '0;
  logic [7:0] r_in = '0, g_in = '0, b_in = '0;
  logic [7:0] power_lvl = '0;
  logic       power_warn = 1'b0;
  logic [8:0] blade_cm;
  logic [7:0] r_out, g_out, b_out;
  logic [1:0] state;
  logic       ign_done, ret_done, busy;

  blade_ignition_sequencer #(
    .STEP_CM(5), .STEP_DIV(4), .FLICKER_DIV(8)
  ) dut (
    .clk(clk), .rst(rst), .on_in(on_in), .len_m(len_m), .len_cm(len_cm),
    .r_in(r_in), .g_in(g_in), .b_in(b_in), .power_lvl(power_lvl),
    .power_warn(power_warn), .blade_cm(blade_cm), .r_out(r_out),
    .g_out(g_out), .b_out(b_out), .state(state), .ign_done(ign_done),
    .ret_done(ret_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    string      name;
    logic [8:0] blade;
    logic [1:0] st;
    logic [7:0] r, g, b;
    logic       ign, ret;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic expect_at(input int c, input string nm, input int bl, input int st,
                           input int r, input int g, input int b,
                           input bit ign, input bit ret);
    exp_t e;
    e.cyc = c; e.name = nm; e.blade = 9'(bl); e.st = 2'(st);
    e.r = 8'(r); e.g = 8'(g); e.b = 8'(b); e.ign = ign; e.ret = ret;
    q.push_back(e);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: output is presented every cycle; compare whatever is due now.
  initial begin
    exp_t e;
    bit   pulse_ok;
    forever begin
      @(negedge clk);
      pulse_ok = 1'b0;
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        checks++;
        if (e.cyc != cyc ||
            {blade_cm, state, r_out, g_out, b_out, ign_done, ret_done} !==
            {e.blade, e.st, e.r, e.g, e.b, e.ign, e.ret}) begin
          errors++;
          $display("FAIL %s cyc=%0d got blade=%0d st=%0d rgb=(%0d,%0d,%0d) ign=%0b ret=%0b want blade=%0d st=%0d rgb=(%0d,%0d,%0d) ign=%0b ret=%0b @cyc %0d",
                   e.name, cyc, blade_cm, state, r_out, g_out, b_out, ign_done, ret_done,
                   e.blade, e.st, e.r, e.g, e.b, e.ign, e.ret, e.cyc);
        end
        if (e.ign || e.ret) pulse_ok = 1'b1;
      end
      checks++;
      if ((ign_done || ret_done || busy !== (state == 2'd1 || state == 2'd3)) && !pulse_ok) begin
        errors++;
        $display("FAIL unexpected_pulse_or_busy cyc=%0d got ign=%0b ret=%0b busy=%0b st=%0d want no pulse, busy matching state",
                 cyc, ign_done, ret_done, busy, state);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int b, b2;
    // Reset held, then release with ignition configuration loaded.
    wait_cyc(2);
    expect_at(3, "reset_state", 0, 0, 0, 0, 0, 0, 0);
    wait_cyc(4);
    rst = 1'b1;
    len_m = 2'd1; len_cm = 6'd50;
    r_in = 8'd255; g_in = 8'd47; b_in = 8'd3;
    power_lvl = 8'd200;
    expect_at(5, "idle_off", 0, 0, 0, 0, 0, 0, 0);

    // Ignition to 1.50 m.
    wait_cyc(6); b = cyc;
    on_in = 1'b1;
    expect_at(b+1,   "ign_enter",   0,   1, 0, 0, 0, 0, 0);
    expect_at(b+4,   "ign_prestep", 0,   1, 0, 0, 0, 0, 0);
    expect_at(b+5,   "ign_step1",   5,   1, 0, 0, 0, 0, 0);
    expect_at(b+6,   "ign_colour",  5,   1, 255, 47, 3, 0, 0);
    expect_at(b+9,   "ign_step2",   10,  1, 255, 47, 3, 0, 0);
    expect_at(b+121, "ign_full",    150, 1, 255, 47, 3, 0, 0);
    expect_at(b+122, "ign_done",    150, 2, 255, 47, 3, 1, 0);
    expect_at(b+123, "on_hold",     150, 2, 255, 47, 3, 0, 0);

    // Power exhaustion while on.
    wait_cyc(b+124); b = cyc;
    power_lvl = 8'd0;
    expect_at(b+1,   "pwr_ret_enter", 150, 3, 255, 47, 3, 0, 0);
    expect_at(b+5,   "pwr_ret_step",  145, 3, 255, 47, 3, 0, 0);
    expect_at(b+121, "pwr_ret_zero",  0,   3, 255, 47, 3, 0, 0);
    expect_at(b+122, "pwr_ret_done",  0,   0, 0, 0, 0, 0, 1);
    expect_at(b+123, "pwr_off",       0,   0, 0, 0, 0, 0, 0);

    // Power restored -> ignite, abort at 60 cm.
    wait_cyc(b+124); b = cyc;
    power_lvl = 8'd200;
    expect_at(b+1,  "abort_ign_enter", 0,  1, 0, 0, 0, 0, 0);
    expect_at(b+49, "abort_at60",      60, 1, 255, 47, 3, 0, 0);
    wait_cyc(b+49);
    on_in = 1'b0;
    expect_at(b+50,  "abort_ret_enter", 60, 3, 255, 47, 3, 0, 0);
    expect_at(b+54,  "abort_ret_step",  55, 3, 255, 47, 3, 0, 0);
    expect_at(b+98,  "abort_ret_zero",  0,  3, 255, 47, 3, 0, 0);
    expect_at(b+99,  "abort_ret_done",  0,  0, 0, 0, 0, 0, 1);
    expect_at(b+100, "abort_off",       0,  0, 0, 0, 0, 0, 0);

    // Re-ignite, then power warning flicker in ON.
    wait_cyc(b+101); b = cyc;
    on_in = 1'b1;
    expect_at(b+122, "reign_done", 150, 2, 255, 47, 3, 1, 0);
    wait_cyc(b+125); b2 = cyc;
    r_in = 8'd33; g_in = 8'd255; b_in = 8'd3;
    power_warn = 1'b1;
    expect_at(b2+1,  "warn_full0", 150, 2, 33, 255, 3, 0, 0);
    expect_at(b2+8,  "warn_full1", 150, 2, 33, 255, 3, 0, 0);
    expect_at(b2+9,  "warn_dim0",  150, 2, 16, 127, 1, 0, 0);
    expect_at(b2+16, "warn_dim1",  150, 2, 16, 127, 1, 0, 0);
    expect_at(b2+17, "warn_full2", 150, 2, 33, 255, 3, 0, 0);
    wait_cyc(b2+20);
    power_warn = 1'b0;
    r_in = 8'd255; g_in = 8'd47; b_in = 8'd3;
    expect_at(b2+21, "warn_clear", 150, 2, 255, 47, 3, 0, 0);

    // Length grows to 2.33 m, then shrinks to 0.40 m.
    wait_cyc(b2+22); b = cyc;
    len_m = 2'd2; len_cm = 6'd33;
    expect_at(b+1,  "grow_enter", 150, 1, 255, 47, 3, 0, 0);
    expect_at(b+5,  "grow_step",  155, 1, 255, 47, 3, 0, 0);
    expect_at(b+69, "grow_sat",   233, 1, 255, 47, 3, 0, 0);
    expect_at(b+70, "grow_done",  233, 2, 255, 47, 3, 1, 0);
    wait_cyc(b+72); b = cyc;
    len_m = 2'd0; len_cm = 6'd40;
    expect_at(b+1, "shrink_snap", 40, 2, 255, 47, 3, 0, 0);
    expect_at(b+3, "shrink_hold", 40, 2, 255, 47, 3, 0, 0);

    // Switch off, then zero-length ignition.
    wait_cyc(b+4); b = cyc;
    on_in = 1'b0;
    expect_at(b+1,  "off40_enter", 40, 3, 255, 47, 3, 0, 0);
    expect_at(b+33, "off40_zero",  0,  3, 255, 47, 3, 0, 0);
    expect_at(b+34, "off40_done",  0,  0, 0, 0, 0, 0, 1);
    wait_cyc(b+36); b = cyc;
    len_cm = 6'd0;
    on_in = 1'b1;
    expect_at(b+1, "zero_ign",  0, 1, 0, 0, 0, 0, 0);
    expect_at(b+2, "zero_done", 0, 2, 0, 0, 0, 1, 0);
    expect_at(b+3, "zero_on",   0, 2, 0, 0, 0, 0, 0);

    // Grow to 1.00 m, retract, assert async reset mid-retraction.
    wait_cyc(b+4); b = cyc;
    len_m = 2'd1;
    expect_at(b+1,  "r_ign_enter", 0,   1, 0, 0, 0, 0, 0);
    expect_at(b+82, "r_ign_done",  100, 2, 255, 47, 3, 1, 0);
    wait_cyc(b+84); b = cyc;
    on_in = 1'b0;
    expect_at(b+1, "r_ret_enter", 100, 3, 255, 47, 3, 0, 0);
    expect_at(b+9, "r_ret_mid",   90,  3, 255, 47, 3, 0, 0);
    wait_cyc(b+10);
    expect_at(b+10, "async_reset", 0, 0, 0, 0, 0, 0, 0);
    #1 rst = 1'b0;   // between edges: must clear before the next rising edge
    wait_cyc(b+12);
    rst = 1'b1;
    expect_at(b+13, "post_reset_off", 0, 0, 0, 0, 0, 0, 0);

    wait_cyc(b+16);
    if (q.size() != 0) begin
      errors += q.size();
      $display("FAIL pending_expectations got %0d left want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
